// File: rtl/triangle_assembler.sv
// triangle_assembler: groups every three incoming vertices into a triangle and buffers triangles in a FIFO
module triangle_assembler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [11:0]           index_id_in,
    input  logic [2:0][31:0]      position_in,
    input  logic [2:0][31:0]      normal_in,
    input  logic [11:0]           material_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [9:0]            triangle_id_out,
    output logic [2:0][2:0][31:0] position_out,
    output logic [2:0][2:0][31:0] normal_out,
    output logic [11:0]           material_out,
    output logic                  overflow_out
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [1:0]                 rst_sync;
    logic                       rst_n;
    logic [1:0]                 slot;
    logic [1:0][2:0][31:0]      pos_stg;
    logic [1:0][2:0][31:0]      nrm_stg;
    logic [11:0]                mat_stg;
    logic [2:0][2:0][31:0]      pos_mem [FIFO_DEPTH];
    logic [2:0][2:0][31:0]      nrm_mem [FIFO_DEPTH];
    logic [9:0]                 id_mem  [FIFO_DEPTH];
    logic [11:0]                mat_mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [AW:0]                count;
    logic [9:0]                 tri_id;
    logic                       push;
    logic                       pop;
    logic                       accept;
    logic                       unused_index;

    // the vertex index is not part of the assembled triangle
    assign unused_index = ^index_id_in;

    assign push   = valid_in && slot == 2'd2;
    assign pop    = valid_out && ready_in;
    assign accept = push && (count != FULL || pop);

    // reset asserts immediately but releases two clocks after rst_in rises
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // vertices 0 and 1 wait in staging; vertex 2 goes straight into the FIFO
    always_ff @(posedge clk_in) begin
        if (valid_in && slot != 2'd2) begin
            pos_stg[slot[0]] <= position_in;
            nrm_stg[slot[0]] <= normal_in;
            if (slot == 2'd0) mat_stg <= material_in;
        end
    end

    // FIFO storage write of a completed, accepted triangle
    always_ff @(posedge clk_in) begin
        if (accept) begin
            pos_mem[wr_ptr] <= {position_in, pos_stg[1], pos_stg[0]};
            nrm_mem[wr_ptr] <= {normal_in, nrm_stg[1], nrm_stg[0]};
            id_mem[wr_ptr]  <= tri_id;
            mat_mem[wr_ptr] <= mat_stg;
        end
    end

    // assembly slot, FIFO pointers, occupancy, id counter and sticky overflow
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tri_id       <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (valid_in) slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            wr_ptr       <= wr_ptr + AW'(accept);
            rd_ptr       <= rd_ptr + AW'(pop);
            count        <= count + (AW + 1)'(accept) - (AW + 1)'(pop);
            tri_id       <= tri_id + 10'(accept);
            overflow_out <= overflow_out | (push && !accept);
        end
    end

    assign valid_out       = count != '0;
    assign triangle_id_out = valid_out ? id_mem[rd_ptr]  : '0;
    assign position_out    = valid_out ? pos_mem[rd_ptr] : '0;
    assign normal_out      = valid_out ? nrm_mem[rd_ptr] : '0;
    assign material_out    = valid_out ? mat_mem[rd_ptr] : '0;
endmodule
